// File: rtl/cmd_arb_pkg.sv
// cmd_arb_pkg
//   Shared types and helpers for the command arbiter slice.
//   - state_t        : dispatcher FSM state encoding
//   - DEF_CLK_FREQ   : default clock frequency, Hz
//   - pulse_cycles_for / reset_cycles_for : default strobe and reset-stretch lengths
//   - idx_width      : source index width, never below 1 bit
//   - cnt_width      : down-counter width able to hold the larger load value
package cmd_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RST   = 3'd1,
    ST_INIT  = 3'd2,
    ST_ADDR  = 3'd3,
    ST_WRITE = 3'd4
  } state_t;

  localparam int DEF_CLK_FREQ = 200000000;

  function automatic int pulse_cycles_for(input int clk_freq);
    return clk_freq / 2500000;
  endfunction

  function automatic int reset_cycles_for(input int clk_freq);
    return clk_freq / 1000;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/cmd_rr_arbiter.sv
// cmd_rr_arbiter
//   Round-robin picker. Combinational search starting one past the last
//   winner; the pointer register moves to the winner when advance is high.
//   Ports:
//     clk, reset    clock, synchronous active-low reset (pointer -> N_SRC-1)
//     req           pending vector, one bit per source
//     advance       accept the current grant and move the pointer
//     grant_valid   some source is requesting
//     grant_idx     index of the selected source
//     grant_onehot  one-hot form of grant_idx (all zero when none)
module cmd_rr_arbiter
  import cmd_arb_pkg::*;
#(
  parameter int N_SRC = 2,
  localparam int IDX_W = idx_width(N_SRC)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] req,
  input  logic             advance,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic [N_SRC-1:0] grant_onehot
);

  logic [IDX_W-1:0] ptr;
  int               cand;

  always_comb begin
    grant_valid  = 1'b0;
    grant_idx    = '0;
    grant_onehot = '0;
    cand         = 0;
    for (int k = 0; k < N_SRC; k++) begin
      cand = (int'(ptr) + 1 + k) % N_SRC;
      if (!grant_valid && req[cand]) begin
        grant_valid        = 1'b1;
        grant_idx          = IDX_W'(cand);
        grant_onehot[cand] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr <= IDX_W'(N_SRC - 1);
    end else if (advance) begin
      ptr <= grant_idx;
    end
  end

endmodule

// File: rtl/cmd_arbiter.sv
// cmd_arbiter
//   N-source command dispatcher. Latches per-source address-set and write
//   requests, serves them round-robin over one shared addr/data_out bus with a
//   fixed-length sw_out strobe, and turns a write of RST_CODE to RST_ADDR into a
//   stretched reset_out.
//   Ports:
//     clk, reset    clock, synchronous active-low reset
//     init          pulse: clear addr to 0 (queued, served from IDLE)
//     src_we_addr   per-source address-set request pulse
//     src_addr      per-source address, source i at [i*ADDR_W +: ADDR_W]
//     src_write     per-source write request pulse
//     src_data      per-source write data, packed like src_addr
//     reset_out     stretched reset for downstream logic
//     addr          current register address
//     data_out      current write data
//     sw_out        write strobe, PULSE_CYCLES long
//     busy          FSM not in IDLE
//     grant_src     source of the operation in progress
//     drop_count    (only with CMD_ARB_DROP_CNT_EN) saturating count of
//                   requests that overwrote a still-pending request
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting; picks init first, then the round-robin winner
//   ST_RST   | reset_out held high until the counter expires
//   ST_INIT  | one cycle with addr cleared, pending init dropped
//   ST_ADDR  | addr driven for PULSE_CYCLES
//   ST_WRITE | data_out driven and sw_out high for PULSE_CYCLES
module cmd_arbiter
  import cmd_arb_pkg::*;
#(
  parameter int N_SRC        = 2,
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int CLK_FREQ     = DEF_CLK_FREQ,
  parameter int PULSE_CYCLES = pulse_cycles_for(CLK_FREQ),
  parameter int RESET_CYCLES = reset_cycles_for(CLK_FREQ),
  parameter int RST_ADDR     = 1,
  parameter int RST_CODE     = 2,
  localparam int IDX_W       = idx_width(N_SRC)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    init,
  input  logic [N_SRC-1:0]        src_we_addr,
  input  logic [N_SRC*ADDR_W-1:0] src_addr,
  input  logic [N_SRC-1:0]        src_write,
  input  logic [N_SRC*DATA_W-1:0] src_data,
  output logic                    reset_out,
  output logic [ADDR_W-1:0]       addr,
  output logic [DATA_W-1:0]       data_out,
  output logic                    sw_out,
  output logic                    busy,
  output logic [IDX_W-1:0]        grant_src
`ifdef CMD_ARB_DROP_CNT_EN
  ,
  output logic [15:0]             drop_count
`endif
);

  localparam int CNT_W = cnt_width(PULSE_CYCLES, RESET_CYCLES);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [N_SRC-1:0]   pend_addr, pend_wr;
  logic               pend_init;
  logic [ADDR_W-1:0]  addr_pl [N_SRC];
  logic [DATA_W-1:0]  data_pl [N_SRC];

  logic               grant_valid;
  logic [IDX_W-1:0]   grant_idx;
  logic [N_SRC-1:0]   grant_onehot;
  logic               advance, cnt_done, rst_match, soft_rst;
  logic [N_SRC-1:0]   clr_addr, clr_wr;

  cmd_rr_arbiter #(.N_SRC(N_SRC)) u_rr (
    .clk          (clk),
    .reset        (reset),
    .req          (pend_addr | pend_wr),
    .advance      (advance),
    .grant_valid  (grant_valid),
    .grant_idx    (grant_idx),
    .grant_onehot (grant_onehot)
  );

  assign busy      = (state != ST_IDLE);
  assign cnt_done  = (cnt == CNT_W'(1));
  assign advance   = (state == ST_IDLE) && !pend_init && grant_valid;
  assign rst_match = (addr == ADDR_W'(RST_ADDR)) && (data_out == DATA_W'(RST_CODE));
  assign soft_rst  = (state == ST_WRITE) && cnt_done && rst_match;

  // A source's address request is always served before its write.
  always_comb begin
    clr_addr = '0;
    clr_wr   = '0;
    if (advance) begin
      if (pend_addr[grant_idx]) clr_addr = grant_onehot;
      else                      clr_wr   = grant_onehot;
    end
  end

`ifdef CMD_ARB_DROP_CNT_EN
  int drop_sum;
  always_comb begin
    drop_sum = int'(drop_count);
    for (int i = 0; i < N_SRC; i++) begin
      drop_sum = drop_sum + int'(src_we_addr[i] && pend_addr[i] && !clr_addr[i])
                          + int'(src_write[i] && pend_wr[i] && !clr_wr[i]);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_RST;
      cnt       <= CNT_W'(RESET_CYCLES);
      reset_out <= 1'b1;
      addr      <= '0;
      data_out  <= '0;
      sw_out    <= 1'b0;
      grant_src <= '0;
      pend_addr <= '0;
      pend_wr   <= '0;
      pend_init <= 1'b0;
      for (int i = 0; i < N_SRC; i++) begin
        addr_pl[i] <= '0;
        data_pl[i] <= '0;
      end
`ifdef CMD_ARB_DROP_CNT_EN
      drop_count <= '0;
`endif
    end else begin
      // New requests win over a same-edge clear, including the soft-reset flush.
      pend_addr <= (soft_rst ? '0 : (pend_addr & ~clr_addr)) | src_we_addr;
      pend_wr   <= (soft_rst ? '0 : (pend_wr & ~clr_wr)) | src_write;
      if (init && state != ST_RST && !soft_rst) pend_init <= 1'b1;
      else if (state == ST_INIT || soft_rst)     pend_init <= 1'b0;

      for (int i = 0; i < N_SRC; i++) begin
        if (src_we_addr[i]) addr_pl[i] <= src_addr[i*ADDR_W +: ADDR_W];
        if (src_write[i])   data_pl[i] <= src_data[i*DATA_W +: DATA_W];
      end

`ifdef CMD_ARB_DROP_CNT_EN
      if (soft_rst)              drop_count <= '0;
      else if (drop_sum > 65535) drop_count <= 16'hFFFF;
      else                       drop_count <= 16'(drop_sum);
`endif

      case (state)
        ST_IDLE: begin
          if (pend_init) begin
            state <= ST_INIT;
            addr  <= '0;
          end else if (grant_valid) begin
            grant_src <= grant_idx;
            cnt       <= CNT_W'(PULSE_CYCLES);
            if (pend_addr[grant_idx]) begin
              state <= ST_ADDR;
              addr  <= addr_pl[grant_idx];
            end else begin
              state    <= ST_WRITE;
              data_out <= data_pl[grant_idx];
              sw_out   <= 1'b1;
            end
          end
        end
        ST_INIT: state <= ST_IDLE;
        ST_ADDR: begin
          if (cnt_done) state <= ST_IDLE;
          else          cnt   <= cnt - 1'b1;
        end
        ST_WRITE: begin
          if (cnt_done) begin
            sw_out <= 1'b0;
            if (rst_match) begin
              state     <= ST_RST;
              reset_out <= 1'b1;
              addr      <= '0;
              cnt       <= CNT_W'(RESET_CYCLES);
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RST: begin
          if (cnt_done) begin
            reset_out <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_arbiter.sv
module tb_cmd_arbiter;

  localparam int PULSE = 4;
  localparam int RSTC  = 10;

  typedef struct {
    int kind;     // 0 addr, 1 write, 2 init
    int src;
    int val;
    int busy_len;
    int sw_len;
    int rst_len;
    int gap;      // idle cycles before this op, -1 = don't care
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        init = 1'b0;
  logic [1:0]  src_we_addr = '0;
  logic [15:0] src_addr = '0;
  logic [1:0]  src_write = '0;
  logic [15:0] src_data = '0;
  logic        reset_out;
  logic [7:0]  addr;
  logic [7:0]  data_out;
  logic        sw_out;
  logic        busy;
  logic [0:0]  grant_src;
`ifdef CMD_ARB_DROP_CNT_EN
  logic [15:0] drop_count;
`endif

  int   n_chk = 0;
  int   n_fail = 0;
  exp_t q[$];
  exp_t cur;
  bit   mon_en = 0;
  bit   active = 0;
  bit   have = 0;
  int   blen, slen, rlen;
  int   idle_cnt = 0;
  logic prev_busy = 1'b0;

  cmd_arbiter #(
    .N_SRC(2), .ADDR_W(8), .DATA_W(8), .CLK_FREQ(200000000),
    .PULSE_CYCLES(PULSE), .RESET_CYCLES(RSTC), .RST_ADDR(1), .RST_CODE(2)
  ) dut (
    .clk(clk), .reset(reset), .init(init),
    .src_we_addr(src_we_addr), .src_addr(src_addr),
    .src_write(src_write), .src_data(src_data),
    .reset_out(reset_out), .addr(addr), .data_out(data_out),
    .sw_out(sw_out), .busy(busy), .grant_src(grant_src)
`ifdef CMD_ARB_DROP_CNT_EN
    , .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_op(input int kind, input int src, input int val, input int bl,
                         input int sl, input int rl, input int gap);
    exp_t e;
    e.kind = kind; e.src = src; e.val = val;
    e.busy_len = bl; e.sw_len = sl; e.rst_len = rl; e.gap = gap;
    q.push_back(e);
  endtask

  // Called at a negedge; drives a one-edge request pulse and returns at the next negedge.
  task automatic req(input logic [1:0] wa, input logic [15:0] av, input logic [1:0] wr,
                     input logic [15:0] dv, input logic in);
    src_we_addr = wa; src_addr = av; src_write = wr; src_data = dv; init = in;
    @(negedge clk);
    src_we_addr = '0; src_write = '0; init = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((q.size() != 0 || active || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_budget", 32'(n < budget), 32'd1);
  endtask

  // Scoreboard monitor: one expected entry per busy burst.
  always @(negedge clk) begin
    if (!mon_en) begin
      active = 0; have = 0; idle_cnt = 0; prev_busy = busy;
    end else begin
      if (!active && busy === 1'b1 && prev_busy === 1'b0) begin
        active = 1; blen = 0; slen = 0; rlen = 0;
        have = (q.size() != 0);
        chk("op_expected", 32'(have), 32'd1);
        if (have) begin
          cur = q.pop_front();
          chk("op_is_write", 32'(sw_out), 32'(cur.kind == 1));
          if (cur.kind == 1) chk("op_data", 32'(data_out), 32'(cur.val));
          else               chk("op_addr", 32'(addr), 32'(cur.val));
          if (cur.kind != 2) chk("op_src", 32'(grant_src), 32'(cur.src));
          if (cur.gap >= 0)  chk("op_gap", 32'(idle_cnt), 32'(cur.gap));
        end
      end
      if (active) begin
        if (busy) begin
          blen++;
          if (sw_out) slen++;
          if (reset_out) rlen++;
        end else begin
          active = 0;
          if (have) begin
            chk("op_busy_len", 32'(blen), 32'(cur.busy_len));
            chk("op_sw_len", 32'(slen), 32'(cur.sw_len));
            chk("op_rst_len", 32'(rlen), 32'(cur.rst_len));
          end
          idle_cnt = 1;
        end
      end else if (!busy) begin
        idle_cnt++;
      end
      prev_busy = busy;
    end
  end

  initial begin
    int n;
    // Hard reset for 5 cycles.
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_reset_out", 32'(reset_out), 32'd1);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_sw_out", 32'(sw_out), 32'd0);
    chk("rst_grant", 32'(grant_src), 32'd0);
    reset = 1'b1;
    n = 0;
    while (reset_out === 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("rst_stretch_len", 32'(n), 32'(RSTC));
    chk("rst_busy_after", 32'(busy), 32'd0);
    chk("rst_addr_after", 32'(addr), 32'd0);
    mon_en = 1;
    @(negedge clk);

    // Tie after reset: pointer starts at src1, so src0 first, then src1.
    push_op(1, 0, 8'h11, PULSE, PULSE, 0, -1);
    push_op(1, 1, 8'h22, PULSE, PULSE, 0, 1);
    req(2'b00, 16'h0, 2'b11, 16'h2211, 1'b0);
    wait_drain(100);
    push_op(1, 0, 8'h13, PULSE, PULSE, 0, -1);
    push_op(1, 1, 8'h24, PULSE, PULSE, 0, 1);
    req(2'b00, 16'h0, 2'b11, 16'h2413, 1'b0);
    wait_drain(100);

    // Single write: 2-edge latency.
    push_op(1, 0, 8'h5A, PULSE, PULSE, 0, -1);
    req(2'b00, 16'h0, 2'b01, 16'h005A, 1'b0);
    chk("lat_not_early", 32'(busy), 32'd0);
    @(negedge clk);
    chk("lat_sw_out", 32'(sw_out), 32'd1);
    chk("lat_data", 32'(data_out), 32'h5A);
    wait_drain(100);

    // src1 addr 0x01 + write 0x02: address first, then soft reset.
    push_op(0, 1, 8'h01, PULSE, 0, 0, -1);
    push_op(1, 1, 8'h02, PULSE + RSTC, PULSE, RSTC, 1);
    req(2'b10, 16'h0100, 2'b10, 16'h0200, 1'b0);
    wait_drain(200);
    chk("soft_rst_addr", 32'(addr), 32'd0);
    chk("soft_rst_released", 32'(reset_out), 32'd0);

    // Two src1 writes during src0 strobe: latest wins.
    push_op(1, 0, 8'h77, PULSE, PULSE, 0, -1);
    push_op(1, 1, 8'h44, PULSE, PULSE, 0, 1);
    req(2'b00, 16'h0, 2'b01, 16'h0077, 1'b0);
    req(2'b00, 16'h0, 2'b10, 16'h3300, 1'b0);
    req(2'b00, 16'h0, 2'b10, 16'h4400, 1'b0);
    wait_drain(100);
`ifdef CMD_ARB_DROP_CNT_EN
    chk("drop_count_one", 32'(drop_count), 32'd1);
`endif

    // init during a strobe: strobe completes, INIT cycle, then pending src1.
    push_op(0, 0, 8'h3C, PULSE, 0, 0, -1);
    req(2'b01, 16'h003C, 2'b00, 16'h0, 1'b0);
    wait_drain(100);
    push_op(1, 0, 8'h55, PULSE, PULSE, 0, -1);
    push_op(2, 0, 8'h00, 1, 0, 0, 1);
    push_op(1, 1, 8'h66, PULSE, PULSE, 0, 1);
    req(2'b00, 16'h0, 2'b01, 16'h0055, 1'b0);
    req(2'b00, 16'h0, 2'b10, 16'h6600, 1'b1);
    wait_drain(100);
    chk("init_addr_cleared", 32'(addr), 32'd0);

    // Hard reset mid-strobe aborts immediately.
    mon_en = 0;
    req(2'b00, 16'h0, 2'b01, 16'h00A5, 1'b0);
    @(negedge clk);
    chk("abort_pre_sw", 32'(sw_out), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_sw_out", 32'(sw_out), 32'd0);
    chk("abort_reset_out", 32'(reset_out), 32'd1);
    chk("abort_data", 32'(data_out), 32'd0);
`ifdef CMD_ARB_DROP_CNT_EN
    chk("abort_drop_clear", 32'(drop_count), 32'd0);
`endif
    reset = 1'b1;
    n = 0;
    while (reset_out === 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("abort_stretch_len", 32'(n), 32'(RSTC));
    chk("abort_busy_after", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
